// File: rtl/flood_reveal_ctrl.sv
// Reveal sequencer for the minesweeper board: owns the revealed bitmap and
// floods zero-adjacency regions breadth-first through an internal tile FIFO.
module flood_reveal_ctrl #(
  parameter int GRID_SIZE = 8,
  parameter int TOTAL     = GRID_SIZE * GRID_SIZE,
  parameter int RC_W      = $clog2(GRID_SIZE),
  parameter int IDX_W     = $clog2(TOTAL),
  parameter int CNT_W     = $clog2(TOTAL + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               adj_valid,
  input  logic [TOTAL-1:0]   mine_map,
  input  logic [TOTAL*4-1:0] adj,
  input  logic               req_valid,
  input  logic [RC_W-1:0]    req_row,
  input  logic [RC_W-1:0]    req_col,
  output logic               req_ready,
  output logic [TOTAL-1:0]   revealed,
  output logic [CNT_W-1:0]   reveal_count,
  output logic               mine_found,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, POP, SCAN, DONE} state_t;

  localparam logic [RC_W:0] GS  = (RC_W+1)'(GRID_SIZE);
  localparam logic [RC_W:0] ONE = (RC_W+1)'(1);

  function automatic logic [IDX_W-1:0] idx(input logic [RC_W-1:0] r, input logic [RC_W-1:0] c);
    return IDX_W'(r) * IDX_W'(GRID_SIZE) + IDX_W'(c);
  endfunction

  state_t            state;
  logic [RC_W-1:0]   cur_row, cur_col;
  logic [2:0]        k;

  logic [2*RC_W-1:0] fifo_mem [TOTAL];
  logic [IDX_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;

  // Request decode
  logic [IDX_W-1:0]  t;
  logic              accept, req_in_grid, req_fresh, req_zero;

  assign req_ready   = (state == IDLE) && adj_valid && !mine_found && !clear;
  assign accept      = req_valid && req_ready;
  assign t           = idx(req_row, req_col);
  assign req_in_grid = ({1'b0, req_row} < GS) && ({1'b0, req_col} < GS);
  assign req_fresh   = req_in_grid && !revealed[t];
  assign req_zero    = (adj[{t, 2'b00} +: 4] == 4'd0);

  // Neighbour k of cur; one extra bit so stepping below 0 lands above GS
  logic [RC_W:0]     dr, dc, nr, nc;
  logic [IDX_W-1:0]  n_idx;
  logic              n_ok, n_new, n_zero;

  always_comb begin
    dr = '0;
    dc = '0;
    case (k)
      3'd0: begin dr = '1;  dc = '1;  end
      3'd1: begin dr = '1;  dc = '0;  end
      3'd2: begin dr = '1;  dc = ONE; end
      3'd3: begin dr = '0;  dc = '1;  end
      3'd4: begin dr = '0;  dc = ONE; end
      3'd5: begin dr = ONE; dc = '1;  end
      3'd6: begin dr = ONE; dc = '0;  end
      default: begin dr = ONE; dc = ONE; end
    endcase
  end

  assign nr     = {1'b0, cur_row} + dr;
  assign nc     = {1'b0, cur_col} + dc;
  assign n_ok   = (nr < GS) && (nc < GS);
  assign n_idx  = idx(nr[RC_W-1:0], nc[RC_W-1:0]);
  assign n_new  = n_ok && !revealed[n_idx] && !mine_map[n_idx];
  assign n_zero = (adj[{n_idx, 2'b00} +: 4] == 4'd0);

  // FIFO control; a push and a pop never share a cycle
  logic              push_en, pop_en;
  logic [2*RC_W-1:0] push_data;

  assign push_en   = (accept && req_fresh && !mine_map[t] && req_zero) ||
                     ((state == SCAN) && !clear && n_new && n_zero);
  assign push_data = (state == SCAN) ? {nr[RC_W-1:0], nc[RC_W-1:0]} : {req_row, req_col};
  assign pop_en    = (state == POP) && !clear && (fifo_cnt != '0);

  always_ff @(posedge clk) begin
    if (push_en) fifo_mem[wr_ptr] <= push_data;
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      revealed     <= '0;
      reveal_count <= '0;
      mine_found   <= 1'b0;
      cur_row      <= '0;
      cur_col      <= '0;
      k            <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
    end else if (clear) begin
      state        <= IDLE;
      revealed     <= '0;
      reveal_count <= '0;
      mine_found   <= 1'b0;
      k            <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (!req_fresh) begin
            state <= DONE;
          end else if (mine_map[t]) begin
            revealed[t] <= 1'b1;
            mine_found  <= 1'b1;
            state       <= DONE;
          end else begin
            revealed[t]  <= 1'b1;
            reveal_count <= reveal_count + CNT_W'(1);
            state        <= POP;
          end
        end
        POP: begin
          if (fifo_cnt == '0) begin
            state <= DONE;
          end else begin
            {cur_row, cur_col} <= fifo_mem[rd_ptr];
            k                  <= '0;
            state              <= SCAN;
          end
        end
        SCAN: begin
          if (n_new) begin
            revealed[n_idx] <= 1'b1;
            reveal_count    <= reveal_count + CNT_W'(1);
          end
          k <= k + 3'd1;
          if (k == 3'd7) state <= POP;
        end
        default: state <= IDLE;
      endcase

      if (push_en) begin
        wr_ptr   <= (wr_ptr == IDX_W'(TOTAL-1)) ? '0 : wr_ptr + IDX_W'(1);
        fifo_cnt <= fifo_cnt + CNT_W'(1);
      end
      if (pop_en) begin
        rd_ptr   <= (rd_ptr == IDX_W'(TOTAL-1)) ? '0 : rd_ptr + IDX_W'(1);
        fifo_cnt <= fifo_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_flood_reveal_ctrl.sv
// Bench for flood_reveal_ctrl: directed scenarios plus random boards, checked
// against a set-based BFS reveal model with a cycle-cost latency estimate.
module tb_flood_reveal_ctrl;
  localparam int G = 8;
  localparam int T = G * G;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           clear = 1'b0;
  logic           adj_valid = 1'b1;
  logic [T-1:0]   mine_map = '0;
  logic [T*4-1:0] adj = '0;
  logic           req_valid = 1'b0;
  logic [2:0]     req_row = '0;
  logic [2:0]     req_col = '0;
  logic           req_ready;
  logic [T-1:0]   revealed;
  logic [6:0]     reveal_count;
  logic           mine_found, busy, done;

  flood_reveal_ctrl #(.GRID_SIZE(G)) dut (
    .clk(clk), .rst(rst), .clear(clear), .adj_valid(adj_valid),
    .mine_map(mine_map), .adj(adj), .req_valid(req_valid),
    .req_row(req_row), .req_col(req_col), .req_ready(req_ready),
    .revealed(revealed), .reveal_count(reveal_count),
    .mine_found(mine_found), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int           n_chk = 0;
  int           n_fail = 0;
  logic [T-1:0] mrev;
  int           mcnt;
  bit           mmine;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int adj_of(input int i);
    return int'(adj[4*i +: 4]);
  endfunction

  // Reference: reveal set by plain BFS; each zero tile costs 9 cycles, plus final POP and DONE
  task automatic model_req(input int r, input int c, output int lat);
    int q[$];
    int zeros, cur, cr, cc, nr, nc, n, ti;
    ti = r * G + c;
    if (r >= G || c >= G || mrev[ti]) begin
      lat = 1;
    end else if (mine_map[ti]) begin
      mrev[ti] = 1'b1;
      mmine = 1'b1;
      lat = 1;
    end else begin
      mrev[ti] = 1'b1;
      mcnt++;
      zeros = 0;
      if (adj_of(ti) == 0) q.push_back(ti);
      while (q.size() > 0) begin
        cur = q.pop_front();
        zeros++;
        cr = cur / G;
        cc = cur % G;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            nr = cr + dr;
            nc = cc + dc;
            if ((dr != 0 || dc != 0) && nr >= 0 && nr < G && nc >= 0 && nc < G) begin
              n = nr * G + nc;
              if (!mrev[n] && !mine_map[n]) begin
                mrev[n] = 1'b1;
                mcnt++;
                if (adj_of(n) == 0) q.push_back(n);
              end
            end
          end
      end
      lat = 9 * zeros + 2;
    end
  endtask

  task automatic req(input int r, input int c, input string tag);
    int  exp_lat, lat;
    bit  exp_ready, busy_ok;
    exp_ready = !mmine && adj_valid;
    @(negedge clk);
    chk({tag, ".ready"}, 64'(req_ready), 64'(exp_ready));
    req_valid = 1'b1;
    req_row = 3'(r);
    req_col = 3'(c);
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (!exp_ready) begin
      chk({tag, ".ign_done"}, 64'(done), 64'(0));
      chk({tag, ".ign_rev"}, 64'(revealed), 64'(mrev));
      return;
    end
    model_req(r, c, exp_lat);
    lat = 1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 1000) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1 lat++;
    end
    if (busy !== 1'b1) busy_ok = 1'b0;
    chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".busy"}, 64'(busy_ok), 64'(1));
    chk({tag, ".revealed"}, 64'(revealed), 64'(mrev));
    chk({tag, ".count"}, 64'(reveal_count), 64'(mcnt));
    chk({tag, ".mine"}, 64'(mine_found), 64'(mmine));
    @(posedge clk);
    #1;
    chk({tag, ".done_pulse"}, 64'({done, busy}), 64'(0));
  endtask

  task automatic model_clear();
    mrev = '0;
    mcnt = 0;
    mmine = 1'b0;
  endtask

  task automatic do_clear(input string tag);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    model_clear();
    chk({tag, ".clr_rev"}, 64'(revealed), 64'(0));
    chk({tag, ".clr_cnt"}, 64'({mine_found, reveal_count}), 64'(0));
  endtask

  task automatic fill_adj(input int v);
    for (int i = 0; i < T; i++) adj[4*i +: 4] = 4'(v);
  endtask

  task automatic start_flood_then_abort(input bit use_rst, input string tag);
    @(negedge clk);
    req_valid = 1'b1;
    req_row = 3'd0;
    req_col = 3'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (99) @(posedge clk);
    @(negedge clk);
    if (use_rst) begin
      rst = 1'b0;
      #1;
    end else begin
      clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
    end
    model_clear();
    chk({tag, ".rev"}, 64'(revealed), 64'(0));
    chk({tag, ".cnt"}, 64'(reveal_count), 64'(0));
    chk({tag, ".idle"}, 64'({busy, done}), 64'(0));
    if (use_rst) begin
      @(negedge clk);
      rst = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk({tag, ".no_done"}, 64'({busy, done}), 64'(0));
    end
    req(0, 0, {tag, ".reflood"});
  endtask

  initial begin
    int r, c;
    model_clear();
    #12;
    chk("reset.rev", 64'(revealed), 64'(0));
    chk("reset.flags", 64'({reveal_count, mine_found, busy, done}), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    #1 chk("reset.ready", 64'(req_ready), 64'(1));

    adj_valid = 1'b0;
    #1 chk("adj_invalid.ready", 64'(req_ready), 64'(0));
    adj_valid = 1'b1;

    // Mine hit at (2,3)
    fill_adj(1);
    mine_map = '0;
    mine_map[19] = 1'b1;
    req(2, 3, "mine");
    chk("mine.bit19", 64'(revealed[19]), 64'(1));
    req(0, 0, "mine_locked");

    // Mine-free all-zero board floods everything
    do_clear("c1");
    mine_map = '0;
    fill_adj(0);
    req(0, 0, "flood_all");
    chk("flood_all.count64", 64'(reveal_count), 64'(64));

    // Single non-zero tile
    do_clear("c2");
    fill_adj(1);
    req(1, 1, "single");
    chk("single.mask", 64'(revealed), 64'h200);

    // Row-edge wrap: zero at (0,7) must not leak into tiles 0 or 8
    do_clear("c3");
    fill_adj(1);
    adj[4*7 +: 4] = 4'd0;
    req(0, 7, "edge");
    chk("edge.mask", 64'(revealed), 64'h000000000000C0C0);
    chk("edge.hidden", 64'({revealed[8], revealed[0]}), 64'(0));
    req(0, 7, "repeat");

    // Abort a flood with clear, then with async reset
    do_clear("c4");
    fill_adj(0);
    start_flood_then_abort(1'b0, "abort_clr");
    do_clear("c5");
    start_flood_then_abort(1'b1, "abort_rst");

    // Random boards
    for (int g = 0; g < 6; g++) begin
      do_clear("rnd_clr");
      for (int i = 0; i < T; i++) mine_map[i] = ($urandom_range(0, 99) < 10 + 3 * g);
      for (int i = 0; i < T; i++) begin
        int cnt;
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            int nr, nc;
            nr = i / G + dr;
            nc = i % G + dc;
            if ((dr != 0 || dc != 0) && nr >= 0 && nr < G && nc >= 0 && nc < G)
              cnt += int'(mine_map[nr * G + nc]);
          end
        adj[4*i +: 4] = 4'(cnt);
      end
      for (int q = 0; q < 6; q++) begin
        if (q == 0 || $urandom_range(0, 3) != 0) begin
          r = int'($urandom_range(0, G - 1));
          c = int'($urandom_range(0, G - 1));
        end
        req(r, c, "rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/flood_reveal_ctrl.md
Name: flood_reveal_ctrl

Overview:
Sequences tile reveals for the minesweeper board. It accepts one reveal request per player action and owns the revealed-tile bitmap. When a revealed tile has adjacency 0, it walks the surrounding region breadth-first using an internal tile-index FIFO, revealing neighbours one per cycle. Its outputs (revealed bitmap, safe-reveal count, mine hit) feed the renderer and the top-level game FSM.

Parameters:
GRID_SIZE, 8, tiles per row/column
TOTAL, GRID_SIZE*GRID_SIZE, tile count
RC_W, $clog2(GRID_SIZE), row/column index width
IDX_W, $clog2(TOTAL), flat tile index width
CNT_W, $clog2(TOTAL+1), reveal counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
clear  in  1  sync new-game clear, highest priority
adj_valid  in  1  adjacency table stable (adj generator done)
mine_map  in  TOTAL  bit i=1 -> mine at tile i, i=row*GRID_SIZE+col
adj  in  TOTAL*4  adj[4i+3:4i] = neighbour mine count of tile i
req_valid  in  1  reveal request
req_row  in  RC_W  requested row
req_col  in  RC_W  requested column
req_ready  out  1  request can be accepted
revealed  out  TOTAL  revealed bitmap
reveal_count  out  CNT_W  number of revealed non-mine tiles
mine_found  out  1  sticky, a mine was revealed
busy  out  1  flood in progress (state != IDLE)
done  out  1  one-cycle pulse, request fully processed

Behaviour:
- Reset (rst=0, async) and clear (sync): revealed=0, reveal_count=0, mine_found=0, FIFO empty, state IDLE, done=0. clear aborts any flood in progress.
- States: IDLE, POP, SCAN, DONE. busy=(state!=IDLE). done=1 exactly while in DONE (Moore). req_ready=(state==IDLE)&&adj_valid&&!mine_found&&!clear.
- Accept = req_valid&&req_ready; t=idx(req_row,req_col). All updates take effect at the accepting edge.
  - req_row or req_col >= GRID_SIZE, or revealed[t]=1: no change; go DONE.
  - mine_map[t]=1: revealed[t]<=1, mine_found<=1, count unchanged; go DONE.
  - Otherwise: revealed[t]<=1, count+=1; push t if adj[t]==0; go POP.
- POP: FIFO empty -> DONE. Else pop cur, k<=0 -> SCAN.
- SCAN: one neighbour per cycle, k=0..7 in order NW,N,NE,W,E,SW,S,SE. A neighbour is skipped if it is off-grid (no wrap across row or column edges), already revealed, or a mine. Otherwise: reveal it, count+=1, push it if its adj==0. After k=7 -> POP.
- DONE -> IDLE after one cycle.
- A tile is pushed only when it is newly revealed, so each tile is pushed at most once. FIFO depth is TOTAL, so it never overflows and no full check is required. A push and a pop never fall in the same cycle.
- Timing:
  - Mine hit, already-revealed tile or invalid index: done in the cycle after the accept.
  - Non-zero safe tile: done 2 cycles after the accept.
  - Flood: each zero tile costs 9 cycles (1 POP + 8 SCAN), plus 1 final POP and 1 DONE cycle.
- req_valid while not ready is ignored, not queued. adj_valid falling mid-flood does not stop the flood.
- reveal_count never exceeds TOTAL.

Test Plan:
- Reset, then request (2,3) on a map with mine at tile 19 and all adj nonzero -> mine_found=1 at accept+1, revealed[19]=1, count=0, done at accept+1. A further request is ignored (req_ready=0).
- Map with no mines (all adj=0), request (0,0) -> flood reveals all 64 tiles, count=64, done exactly 578 cycles after accept.
- Single nonzero tile (adj=1 at tile 9), request (1,1) -> revealed has only bit 9 set, count=1, done 2 cycles after accept, busy high for those 2 cycles.
- Edge wrap: no mines, all adj nonzero except tile 7 (adj=0); request (0,7) -> reveals exactly tiles 6, 7, 14, 15; tiles 8 and 0 stay hidden; count=4.
- Repeat request on an already revealed tile -> revealed and count unchanged, done at accept+1.
- Assert clear mid-flood (no-mine map, 100 cycles after accept) -> next cycle: revealed=0, count=0, state IDLE, no done pulse. Then a fresh request floods normally (count=64). Repeat the same scenario with async rst low instead of clear -> same result.
